// File: rtl/z3_slave_engine_if.sv
// Bus-side bundle of the Zorro III slave-cycle sequencer: decode and strobe inputs,
// per-target acknowledges, and the owner/handshake/status outputs.
interface z3_slave_engine_if #(
  parameter int NUM_TARGETS = 6,
  parameter int ERRCNT_W    = 8
);
  logic                   FCS_n;
  logic                   VALIDSPACE;
  logic [NUM_TARGETS-1:0] MATCH;
  logic                   DOE;
  logic [3:0]             DS_n;
  logic [NUM_TARGETS-1:0] TGT_DTACK;
  logic [NUM_TARGETS-1:0] TGT_SEL;
  logic                   SLAVE_n;
  logic                   DTACK;
  logic                   BERR;
  logic                   BUSY;
  logic [ERRCNT_W-1:0]    ERR_COUNT;

  modport master (
    output FCS_n, VALIDSPACE, MATCH, DOE, DS_n, TGT_DTACK,
    input  TGT_SEL, SLAVE_n, DTACK, BERR, BUSY, ERR_COUNT
  );

  modport slave (
    input  FCS_n, VALIDSPACE, MATCH, DOE, DS_n, TGT_DTACK,
    output TGT_SEL, SLAVE_n, DTACK, BERR, BUSY, ERR_COUNT
  );
endinterface

// File: rtl/z3_slave_engine.sv
// Zorro III slave-cycle sequencer: one-hot owner select over decoded regions, programmable
// minimum wait before DTACK, and a data-phase timeout that answers with BERR and is counted.
module z3_slave_engine #(
  parameter int NUM_TARGETS = 6,
  parameter int MIN_WAIT    = 0,
  parameter int TIMEOUT     = 64,
  parameter int TMR_W       = 8,
  parameter int ERRCNT_W    = 8
) (
  input logic              CLK,
  input logic              RESET,
  z3_slave_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_END,
    S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_TARGETS-1:0] tgt_sel_q, tgt_sel_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [ERRCNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                   dtack_q, dtack_d;
  logic                   berr_q, berr_d;

  logic                   hit;
  logic                   strobe;
  logic                   ack;
  logic                   wait_ok;
  logic                   tmo_hit;
  logic                   busy;
  logic [NUM_TARGETS-1:0] owner_sel;

  assign hit       = !bus.FCS_n && bus.VALIDSPACE && (|bus.MATCH);
  assign strobe    = bus.DOE && (bus.DS_n != 4'b1111);
  // x & -x isolates the lowest set bit, so simultaneous matches resolve to the lowest index.
  assign owner_sel = bus.MATCH & (~bus.MATCH + NUM_TARGETS'(1));
  assign ack       = |(bus.TGT_DTACK & tgt_sel_q);
  assign busy      = (state_q != S_IDLE);

  // Parameter-selected compares keep constant comparisons out of the netlist.
  if (MIN_WAIT == 0) begin : g_no_wait
    assign wait_ok = 1'b1;
  end else begin : g_wait
    assign wait_ok = (timer_q >= TMR_W'(MIN_WAIT));
  end

  if (TIMEOUT == 0) begin : g_no_timeout
    assign tmo_hit = 1'b0;
  end else begin : g_timeout
    assign tmo_hit = (timer_q == TMR_W'(TIMEOUT - 1));
  end

  // NOTE: async reset clears every flop here; there is no storage array that could be left unreset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      tgt_sel_q <= '0;
      timer_q   <= '0;
      err_cnt_q <= '0;
      dtack_q   <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q   <= state_d;
      tgt_sel_q <= tgt_sel_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_START;
      S_START: begin
        if (bus.FCS_n)  state_d = S_IDLE;
        else if (strobe) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.FCS_n)          state_d = S_IDLE;
        else if (ack && wait_ok) state_d = S_END;
        else if (tmo_hit)        state_d = S_ERR;
      end
      S_END, S_ERR: if (bus.FCS_n) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tgt_sel_d = tgt_sel_q;
    if (state_d == S_IDLE)      tgt_sel_d = '0;
    else if (state_q == S_IDLE) tgt_sel_d = owner_sel;

    timer_d = '0;
    if (state_q == S_DATA) begin
      timer_d = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);
    end

    err_cnt_d = err_cnt_q;
    if ((state_q == S_DATA) && (state_d == S_ERR) && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end

    // Registered from the next state so DTACK/BERR are glitch-free and mutually exclusive.
    dtack_d = (state_d == S_END);
    berr_d  = (state_d == S_ERR);
  end

  assign bus.TGT_SEL   = tgt_sel_q;
  assign bus.DTACK     = dtack_q;
  assign bus.BERR      = berr_q;
  assign bus.BUSY      = busy;
  assign bus.ERR_COUNT = err_cnt_q;
  assign bus.SLAVE_n   = !(hit || (busy && !bus.FCS_n));

endmodule
